wishbone_timer_slave: RTL

WISHBONE_TIMER_SLAVE -- requirements
Module: wishbone_timer_slave

---
 rtl/wb_timer_pkg.sv | 26 ++
 rtl/wbt_counter.sv | 64 ++++++
 rtl/wishbone_timer_slave.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/wb_timer_pkg.sv
// Shared definitions for the Wishbone timer slave: register map, CTRL bit layout, bus FSM encoding.
// No logic here; latency and backpressure belong to the modules that import it.
package wb_timer_pkg;

    localparam logic [3:0] OFF_CTRL     = 4'd0;
    localparam logic [3:0] OFF_PRESCALE = 4'd1;
    localparam logic [3:0] OFF_RELOAD   = 4'd2;
    localparam logic [3:0] OFF_COUNT    = 4'd3;
    localparam logic [3:0] OFF_STATUS   = 4'd4;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_AR     = 1;
    localparam int CTRL_IE     = 2;
    localparam int STATUS_FLAG = 0;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACK      = 2'd1;
    localparam logic [1:0] ST_WAIT_REL = 2'd2;

    typedef struct packed {
        logic ie;
        logic autoreload;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/wbt_counter.sv
// Prescaler plus 8-bit down-counter; raises zero_set when COUNT lands on 0 and stop for one-shot expiry.
// Latency: tick and count update take effect on the edge where the prescaler matches PRESCALE.
// Backpressure: none; load/pre_clr are single-cycle commands from the bus side.
module wbt_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       autoreload,
    input  logic [7:0] prescale,
    input  logic [7:0] reload,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       pre_clr,
    output logic [7:0] count,
    output logic       zero_set,
    output logic       stop
);

    logic [7:0] pre_cnt;
    logic       tick;
    logic [7:0] count_nxt;

    assign tick = en && (pre_cnt == prescale);

    // The reload tick counts as one step of the period, so RELOAD=N gives
    // exactly N ticks between flags and RELOAD=0 flags on every tick.
    always_comb begin
        count_nxt = count;
        zero_set  = 1'b0;
        stop      = 1'b0;
        if (tick) begin
            if (count != 8'd0) begin
                count_nxt = count - 8'd1;
                if (count == 8'd1) begin
                    zero_set = 1'b1;
                    stop     = !autoreload;
                end
            end else if (autoreload) begin
                count_nxt = (reload == 8'd0) ? 8'd0 : reload - 8'd1;
                zero_set  = (reload <= 8'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= 8'd0;
            count   <= 8'd0;
        end else begin
            if (pre_clr) begin
                pre_cnt <= 8'd0;
            end else if (en) begin
                pre_cnt <= tick ? 8'd0 : pre_cnt + 8'd1;
            end

            if (load) begin
                count <= load_val;
            end else begin
                count <= count_nxt;
            end
        end
    end

endmodule

// File: rtl/wishbone_timer_slave.sv
// Wishbone slave exposing a prescaled down-counter timer with a maskable interrupt.
// Latency: ack one cycle after select; writes and read data are registered on the select edge.
// Backpressure: one access per strobe; a held strobe parks in WAIT_REL until released.
module wishbone_timer_slave
    import wb_timer_pkg::*;
#(
    parameter logic [7:0] BASE         = 8'hF0,
    parameter logic       AUTOLOAD_DEF = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] dir,
    input  logic        we,
    input  logic        stb,
    input  logic        cyc,
    input  logic [7:0]  dat_i,
    output logic [7:0]  dat_o,
    output logic        ack,
    output logic        irq
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       rearm_wait;
    ctrl_t      ctrl;
    logic [7:0] prescale;
    logic [7:0] reload;
    logic [7:0] count;
    logic       flag;

    logic       sel;
    logic       access;
    logic       wr;
    logic       rd;
    logic [3:0] off;
    logic       wr_ctrl;
    logic       wr_prescale;
    logic       wr_reload;
    logic       wr_status;
    logic       en_rise;
    logic       cnt_load;
    logic       pre_clr;
    logic [7:0] load_val;
    logic [7:0] rd_data;
    logic       zero_set;
    logic       stop;

    assign sel = cyc && stb && (dir[11:4] == BASE);
    // rearm_wait keeps a strobe that was already high across reset from counting as a new access.
    assign access = (state == ST_IDLE) && sel && !rearm_wait;
    assign off    = dir[3:0];
    assign wr     = access && we;
    assign rd     = access && !we;

    assign wr_ctrl     = wr && (off == OFF_CTRL);
    assign wr_prescale = wr && (off == OFF_PRESCALE);
    assign wr_reload   = wr && (off == OFF_RELOAD);
    assign wr_status   = wr && (off == OFF_STATUS);

    assign en_rise  = wr_ctrl && dat_i[CTRL_EN] && !ctrl.en;
    assign cnt_load = (wr_reload && !ctrl.en) || (en_rise && (count == 8'd0));
    assign load_val = wr_reload ? dat_i : reload;
    assign pre_clr  = (wr_reload && !ctrl.en) || en_rise;

    assign ack = (state == ST_ACK);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (access) state_nxt = ST_ACK;
            ST_ACK:      state_nxt = ST_WAIT_REL;
            ST_WAIT_REL: if (!stb || !cyc) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_data = 8'h00;
        case (off)
            OFF_CTRL:     rd_data = {5'b0, ctrl};
            OFF_PRESCALE: rd_data = prescale;
            OFF_RELOAD:   rd_data = reload;
            OFF_COUNT:    rd_data = count;
            OFF_STATUS:   rd_data = {7'b0, flag};
            default:      rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            rearm_wait <= 1'b1;
            dat_o      <= 8'h00;
        end else begin
            state <= state_nxt;
            if (!stb || !cyc) begin
                rearm_wait <= 1'b0;
            end
            if (rd) begin
                dat_o <= rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= '{ie: 1'b0, autoreload: AUTOLOAD_DEF, en: 1'b0};
            prescale <= 8'd0;
            reload   <= 8'd0;
            flag     <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= '{ie: dat_i[CTRL_IE], autoreload: dat_i[CTRL_AR], en: dat_i[CTRL_EN]};
            end else if (stop) begin
                ctrl.en <= 1'b0;
            end
            if (wr_prescale) begin
                prescale <= dat_i;
            end
            if (wr_reload) begin
                reload <= dat_i;
            end
            // An expiry in the same cycle as a write-1-to-clear keeps the flag set.
            if (zero_set) begin
                flag <= 1'b1;
            end else if (wr_status && dat_i[STATUS_FLAG]) begin
                flag <= 1'b0;
            end
            irq <= flag && ctrl.ie;
        end
    end

    wbt_counter u_counter (
        .clk        (clk),
        .reset      (reset),
        .en         (ctrl.en),
        .autoreload (ctrl.autoreload),
        .prescale   (prescale),
        .reload     (reload),
        .load       (cnt_load),
        .load_val   (load_val),
        .pre_clr    (pre_clr),
        .count      (count),
        .zero_set   (zero_set),
        .stop       (stop)
    );

endmodule
